// File: rtl/ksa_wb_responder_if.sv
// Wishbone slave-port bundle for ksa_wb_responder: the classic cyc/stb/we/sel/adr/data/ack set.
interface ksa_wb_responder_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport slave  (input  cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
    modport master (output cyc, stb, we, sel, adr, dat_w, input  ack, dat_r);
endinterface

// File: rtl/ksa_wb_responder.sv
// Wishbone register front-end for a WIDTH-bit add/subtract unit with a LATENCY-cycle busy window.
// Optional done interrupt is enabled by defining KSA_WB_IRQ_EN.
module ksa_wb_responder #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    ksa_wb_responder_if.slave  wbs,
    output logic               busy_o,
    output logic               irq_o
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t            state, state_nx;
    logic              ack, hit, wr, ctrl_wr;
    logic [2:0]        offset;
    logic [WIDTH-1:0]  opa, opb, snap_a, snap_b, sum;
    logic              sub, snap_sub, irq_en, busy, done, cout;
    logic              start, finish, w1c, busy_nx, done_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [WIDTH:0]    calc;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign hit     = wbs.cyc & wbs.stb & (wbs.adr[31:5] == BASE_ADDR[31:5]);
    assign offset  = wbs.adr[4:2];
    assign wr      = hit & ~ack & wbs.we;
    assign ctrl_wr = wr & (offset == 3'd2) & wbs.sel[0];
    assign w1c     = wr & (offset == 3'd3) & wbs.sel[0] & wbs.dat_w[1];

    // Subtraction is A + ~B + 1, so COUT=1 means "no borrow".
    assign calc = {1'b0, snap_a} + {1'b0, snap_sub ? ~snap_b : snap_b} + {{WIDTH{1'b0}}, snap_sub};

    assign wbs.ack   = ack;
    assign busy_o    = busy;
    assign unused_ok = &{1'b0, wbs.adr[1:0], wbs.dat_w};

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [31:0] d, input logic [3:0] sel);
        logic [WIDTH-1:0] r;
        r = old;
        for (int unsigned i = 0; i < WIDTH; i++)
            if (sel[i / 8]) r[i] = d[i];
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = done;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (ctrl_wr && wbs.dat_w[0]) begin
                start    = 1'b1;
                state_nx = CALC;
                cnt_nx   = CW'(LATENCY - 1);
            end
            CALC: if (cnt == '0) begin
                finish   = 1'b1;
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
            default: state_nx = IDLE;
        endcase
        // Priority: START over completion/W1C, completion set over W1C.
        if (w1c)    done_nx = 1'b0;
        if (finish) begin busy_nx = 1'b0; done_nx = 1'b1; end
        if (start)  begin busy_nx = 1'b1; done_nx = 1'b0; end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            3'd0: rdata[WIDTH-1:0] = opa;
            3'd1: rdata[WIDTH-1:0] = opb;
            3'd2: rdata[2:1]       = {irq_en, sub};
            3'd3: rdata[2:0]       = {cout, done, busy};
            3'd4: rdata[WIDTH:0]   = {cout, sum};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack       <= 1'b0;
            wbs.dat_r <= '0;
            opa       <= '0;
            opb       <= '0;
            sub       <= 1'b0;
            snap_a    <= '0;
            snap_b    <= '0;
            snap_sub  <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            ack       <= hit & ~ack;
            wbs.dat_r <= (hit & ~ack & ~wbs.we) ? rdata : '0;
            if (wr && offset == 3'd0) opa <= merge(opa, wbs.dat_w, wbs.sel);
            if (wr && offset == 3'd1) opb <= merge(opb, wbs.dat_w, wbs.sel);
            if (ctrl_wr) sub <= wbs.dat_w[1];
            if (start) begin
                snap_a   <= opa;
                snap_b   <= opb;
                snap_sub <= wbs.dat_w[1];
            end
            if (finish) {cout, sum} <= calc;
        end
    end

`ifdef KSA_WB_IRQ_EN
    logic irq;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wbs.dat_w[2];
            irq <= done_nx & (ctrl_wr ? wbs.dat_w[2] : irq_en);
        end
    end

    assign irq_o = irq;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif
endmodule

// File: tb/tb_ksa_wb_responder.sv
// Scoreboard bench for ksa_wb_responder: driver predicts read data from a behavioural model,
// a monitor pops and compares on every ack.
module tb_ksa_wb_responder;
    localparam int          W    = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          LAT  = 4;
    localparam longint      MASK = (64'd1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, irq;

    ksa_wb_responder_if bus();

    ksa_wb_responder #(.WIDTH(W), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs      (bus),
        .busy_o   (busy),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc_n = 0;
    int last_ack = -10;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: registers as plain integers, completion scheduled by cycle number.
    longint m_opa, m_opb, m_sum, s_a, s_b;
    bit     m_sub, m_irqen, m_busy, m_done, m_cout, s_sub;
    int     m_done_cyc;

    task automatic model_reset();
        m_opa = 0; m_opb = 0; m_sum = 0; s_a = 0; s_b = 0;
        m_sub = 0; m_irqen = 0; m_busy = 0; m_done = 0; m_cout = 0; s_sub = 0;
        m_done_cyc = 0;
    endtask

    task automatic model_sync(input int c);
        longint r;
        if (m_busy && m_done_cyc <= c) begin
            r = s_sub ? (s_a + (MASK - s_b) + 1) : (s_a + s_b);
            m_sum  = r & MASK;
            m_cout = ((r >> W) & 1) != 0;
            m_busy = 0;
            m_done = 1;
        end
    endtask

    function automatic longint lane_merge(input longint old, input logic [31:0] d, input logic [3:0] sel);
        longint r = old;
        for (int l = 0; l < 4; l++)
            if (sel[l]) r = (r & ~(longint'(8'hFF) << (8 * l))) | (longint'(d) & (longint'(8'hFF) << (8 * l)));
        return r & MASK;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        logic [31:0] r;
        case (off)
            0: r = 32'(m_opa);
            1: r = 32'(m_opb);
            2: r = {29'd0, m_irqen, m_sub, 1'b0};
            3: r = {29'd0, m_cout, m_done, m_busy};
            4: r = 32'((longint'(m_cout) << W) | m_sum);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit model_irq();
`ifdef KSA_WB_IRQ_EN
        return m_done & m_irqen;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] sel, input int c);
        bit was_busy, fin_now;
        model_sync(c - 1);
        was_busy = m_busy;
        fin_now  = m_busy && (m_done_cyc == c);
        case (off)
            0: m_opa = lane_merge(m_opa, d, sel);
            1: m_opb = lane_merge(m_opb, d, sel);
            2: if (sel[0]) begin
                m_sub = d[1];
`ifdef KSA_WB_IRQ_EN
                m_irqen = d[2];
`endif
                if (d[0] && !was_busy) begin
                    s_a = m_opa; s_b = m_opb; s_sub = m_sub;
                    m_busy = 1; m_done = 0; m_done_cyc = c + LAT;
                end
            end
            3: if (sel[0] && d[1] && !fin_now) m_done = 0;
            default: ;
        endcase
        model_sync(c);
    endtask

    // Monitor: every ack pops one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_ack: ack with empty scoreboard, dat 0x%0h", bus.dat_r);
                end else begin
                    e = sbq.pop_front();
                    check(e.name, longint'(bus.dat_r), longint'(e.exp));
                end
            end
        end
    end

    task automatic bus_op(input bit we, input int off, input logic [31:0] d,
                          input logic [3:0] sel, input string name);
        int   c;
        exp_t e;
        bit   got;
        c = cyc_n + ((last_ack == cyc_n) ? 2 : 1);
        e.name = name;
        if (we) e.exp = '0;
        else begin
            model_sync(c - 1);
            e.exp = model_read(off);
        end
        sbq.push_back(e);
        bus.cyc = 1; bus.stb = 1; bus.we = we; bus.sel = sel;
        bus.adr = BASE + 32'(off * 4); bus.dat_w = d;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack === 1'b1) got = 1;
        end
        bus.cyc = 0; bus.stb = 0; bus.we = 0;
        if (!got) begin
            checks++;
            $display("FAIL %s_ack: no ack within 8 cycles", name);
            void'(sbq.pop_back());
        end else begin
            check({name, "_ack_cycle"}, cyc_n, c);
        end
        last_ack = cyc_n;
        if (we) model_write(off, d, sel, c);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input string name);
        bus_op(1'b1, off, d, 4'hF, name);
    endtask

    task automatic rd(input int off, input string name);
        bus_op(1'b0, off, '0, 4'hF, name);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 64 && cyc_n < target; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_completion(input string name);
        for (int i = 0; i < LAT + 3; i++) begin
            model_sync(cyc_n);
            check({name, "_busy"}, busy, m_busy);
            if (!m_busy) break;
            @(posedge clk);
            #1;
        end
        check({name, "_irq"}, irq, model_irq());
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl, input string name);
        wr(0, a, {name, "_opa"});
        wr(1, b, {name, "_opb"});
        wr(2, ctrl, {name, "_start"});
        expect_completion(name);
        rd(3, {name, "_status"});
        rd(4, {name, "_result"});
    endtask

    initial begin
        int c0, acks;
        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.sel = '0; bus.adr = '0; bus.dat_w = '0;
        model_reset();

        // Reset held while strobing a read.
        bus.cyc = 1; bus.stb = 1; bus.adr = BASE + 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_ack", bus.ack, 0);
            check("rst_dat", bus.dat_r, 0);
            check("rst_busy", busy, 0);
            check("rst_irq", irq, 0);
        end
        bus.cyc = 0; bus.stb = 0;
        rst_n = 1;
        rd(4, "post_rst_result");
        rd(3, "post_rst_status");

        run_op(32'h1234, 32'h4321, 32'h1, "add_basic");
        run_op(32'hFFFF, 32'h0001, 32'h1, "add_carry");
        run_op(32'h0005, 32'h0007, 32'h3, "sub_borrow");
        run_op(32'h0007, 32'h0005, 32'h3, "sub_noborrow");

        // Snapshot isolation: operand rewrite and a second START while busy.
        wr(0, 32'h1111, "snap_opa");
        wr(1, 32'h2222, "snap_opb");
        wr(2, 32'h1, "snap_start");
        wr(0, 32'h7777, "snap_opa_busy");
        wr(2, 32'h1, "snap_start_busy");
        expect_completion("snap");
        rd(4, "snap_result");
        rd(0, "snap_opa_rb");
        wr(3, 32'h2, "w1c");
        rd(3, "w1c_status");

        // W1C landing on the completion edge: set wins.
        wr(2, 32'h1, "race_start");
        c0 = last_ack;
        wait_until(c0 + LAT - 1);
        wr(3, 32'h2, "race_w1c");
        rd(3, "race_status");
        // START clears DONE and raises BUSY.
        wr(2, 32'h1, "restart");
        rd(3, "restart_status");
        expect_completion("restart");

        // Interrupt path (forced low when the feature is absent).
        run_op(32'h0100, 32'h0200, 32'h5, "irq_op");
        wr(3, 32'h2, "irq_w1c");
        check("irq_after_w1c", irq, model_irq());
        wr(2, 32'h5, "irq_start2");
        expect_completion("irq_op2");
        wr(2, 32'h5, "irq_start3");
        check("irq_after_start", irq, model_irq());
        expect_completion("irq_op3");
        rd(2, "ctrl_rb");

        // Byte lanes, unmapped offsets.
        wr(0, 32'h1234, "lane_full");
        bus_op(1'b1, 0, 32'hAABB, 4'h1, "lane_sel1");
        rd(0, "lane_opa");
        bus_op(1'b1, 1, 32'hCCDD, 4'h2, "lane_sel2");
        rd(1, "lane_opb");
        rd(6, "unmapped6");
        wr(7, 32'hFFFF_FFFF, "unmapped7_wr");
        rd(7, "unmapped7");

        // Out-of-window address must never be acked.
        bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = BASE + 32'h20;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack === 1'b1) acks++;
        end
        bus.cyc = 0; bus.stb = 0;
        check("miss_no_ack", acks, 0);

        // Reset mid-operation aborts it.
        wr(2, 32'h1, "abort_start");
        @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        check("abort_busy", busy, 0);
        rd(3, "abort_status");
        rd(4, "abort_result");

        // Randomized operations.
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a, b;
            logic [3:0]  s;
            a = $urandom; b = $urandom; s = 4'($urandom_range(1, 15));
            bus_op(1'b1, 0, a, s, "rnd_opa");
            bus_op(1'b1, 1, b, 4'hF, "rnd_opb");
            wr(2, {29'd0, 1'($urandom), 1'($urandom), 1'b1}, "rnd_start");
            if ($urandom_range(0, 1) == 1) wr(0, $urandom, "rnd_opa_busy");
            expect_completion("rnd");
            rd(4, "rnd_result");
            rd(3, "rnd_status");
            if ($urandom_range(0, 2) == 0) wr(3, 32'h2, "rnd_w1c");
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
